pe_stream_sequencer: RTL and testbench
======================================

// Module: pe_stream_sequencer
// PURPOSE
// - Second-generation control front-end for the systolic pe_array, sitting between the control unit and the array.
// - Accepts a tile command (K depth, accumulate/clear) over valid/ready and streams K operand beats with per-row/col skew.
// - Counts the drain latency from the last beat, then snapshots the array results into a held result buffer.
// - Presents the buffer over valid/ready. Replaces the always-ready, flush-by-zeros scheme with explicit beat accounting.
// PARAMETERS
// - DATA_WIDTH  nmcu_pkg::DATA_WIDTH  operand width
// - PSUM_WIDTH  nmcu_pkg::PSUM_WIDTH  partial-sum/result width
// - PE_ROWS     nmcu_pkg::PE_ROWS     array rows (operand A lanes)
// - PE_COLS     nmcu_pkg::PE_COLS     array cols (operand B lanes)
// - PE_PIPE     4                     internal PE pipeline depth
// - MAX_K       256                   max beats per tile; KW = $clog2(MAX_K+1)
// - SKEW_EN     1                     1: row r delayed r cycles, col c delayed c cycles; 0: no skew
// - DRAIN_LAT   PE_ROWS+PE_COLS-2+PE_PIPE+1  cycles from last-beat handshake to capture
// PORTS
// - clk          in   1                       clock
// - rst_n        in   1                       asynchronous active-low reset
// - cmd_valid_i  in   1                       tile command valid
// - cmd_ready_o  out  1                       high only in IDLE
// - cmd_k_len_i  in   KW                      beats in tile
// - cmd_accum_i  in   1                       1: first beat accumulates onto existing psum; 0: first beat clears
// - op_valid_i   in   1                       operand beat valid
// - op_ready_o   out  1                       high only in STREAM
// - op_last_i    in   1                       producer's last-beat marker (checked, not trusted)
// - op_a_i       in   DATA_WIDTH x PE_ROWS    A lanes
// - op_b_i       in   DATA_WIDTH x PE_COLS    B lanes
// - pe_accum_en_o out PE_ROWS                 to array, skewed with A
// - pe_a_o       out  DATA_WIDTH x PE_ROWS    to array, registered + skewed
// - pe_b_o       out  DATA_WIDTH x PE_COLS    to array, registered + skewed
// - pe_result_i  in   PSUM_WIDTH x ROWS x COLS from array
// - res_valid_o  out  1                       result buffer valid
// - res_ready_i  in   1                       consumer accepts result
// - res_data_o   out  PSUM_WIDTH x ROWS x COLS  held snapshot
// - busy_o       out  1                       state != IDLE
// - err_o        out  1                       sticky protocol error
// BEHAVIOUR
// - Reset: all outputs 0 except cmd_ready_o=1. FSM=IDLE; skew lines, counters and buffer cleared.
//   Reset mid-tile abandons the tile; no result is produced.
// - FSM IDLE -> STREAM on cmd handshake: latch k_len and accum; beat_cnt=0.
//   k_len=0 sets err_o and goes directly to DRAIN.
// - STREAM: each op handshake registers A/B into stage 0.
//   - accum_en = cmd_accum for beat 0, else 1.
//   - No handshake in a cycle: zeros injected, accum_en=1 (bubble is harmless).
//   - beat_cnt increments; on beat k_len-1 go to DRAIN with drain_cnt=DRAIN_LAT-1.
// - op_last_i check: asserted on a beat != k_len-1, or deasserted on beat k_len-1 -> err_o set.
//   beat_cnt alone terminates the tile.
// - DRAIN: zeros and accum_en=1 streamed. drain_cnt decrements; at 0, capture pe_result_i into res_data_o,
//   set res_valid_o and go to RESULT. res_valid_o rises DRAIN_LAT cycles after the last-beat handshake edge.
// - RESULT: res_data_o is stable while res_valid_o=1. On res_ready_i: res_valid_o=0 and go to IDLE.
//   The next cmd is accepted no earlier than the following cycle.
// - Skew: lane i passes through i registers after stage 0 (SKEW_EN=1); accum_en row r follows A row r exactly.
// - err_o is cleared only by reset.
// - Widths: beat_cnt/k_len are KW bits; drain_cnt is $clog2(DRAIN_LAT+1) bits. Counters never wrap (bounded by FSM).
// STRUCTURE
// - nmcu_pkg: pe_seq_state_e {IDLE,STREAM,DRAIN,RESULT} and a PE_PIPE_DEPTH constant.
// - Sub-module skew_line #(WIDTH,DEPTH): a DEPTH-stage shift register with async reset and DEPTH=0 passthrough.
//   Instantiated per A lane (with accum bit) and per B lane via generate.
// TESTING (ROWS=COLS=4, PE_PIPE=4, DRAIN_LAT=11)
// - Reset mid-STREAM (beat 2 of 4) -> busy_o=0, cmd_ready_o=1, res_valid_o=0, pe_a_o all 0 next cycle.
// - cmd k_len=4, accum=0, A=B=1 every beat, op_valid every cycle
//   -> res_valid_o 11 cycles after 4th handshake; each res_data_o = 4 (array model).
// - Same tile with op_valid 1,0,1,0,... -> same result 4; op_ready_o low in DRAIN;
//   pe_a_o row 3 lags row 0 by 3 cycles.
// - Back-to-back tiles k=2 (accum=0) then k=2 (accum=1), A=B=2
//   -> results 8 then 16; no second cmd_ready_o until first res_ready_i.
// - op_last_i on beat 1 of k_len=3 -> err_o=1 sticky; tile still completes after 3 beats.
//   k_len=0 -> err_o=1, res_valid_o after 11 cycles.
// - res_ready_i held 0 for 20 cycles -> res_data_o stable, cmd_ready_o=0; release -> IDLE next cycle.

Source files
------------

// File: rtl/nmcu_pkg.sv
// nmcu_pkg: shared array geometry, data widths and the stream sequencer state encoding.
package nmcu_pkg;
   localparam int DATA_WIDTH    = 8;
   localparam int PSUM_WIDTH    = 32;
   localparam int PE_ROWS       = 4;
   localparam int PE_COLS       = 4;
   localparam int PE_PIPE_DEPTH = 4;
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} pe_seq_state_e;
endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage shift register with async reset; DEPTH=0 is a plain wire.
module skew_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q_o = d_i;
   end else begin : g_sr
      logic [WIDTH-1:0] sr_q [DEPTH];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
         end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
         end
      end
      assign q_o = sr_q[DEPTH-1];
   end
endmodule

// File: rtl/pe_stream_sequencer.sv
// pe_stream_sequencer: accepts a tile command, streams K skewed operand beats into the
// systolic array, waits out the drain latency and holds a snapshot of the array results.
module pe_stream_sequencer #(
   parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
   parameter int PSUM_WIDTH = nmcu_pkg::PSUM_WIDTH,
   parameter int PE_ROWS    = nmcu_pkg::PE_ROWS,
   parameter int PE_COLS    = nmcu_pkg::PE_COLS,
   parameter int PE_PIPE    = nmcu_pkg::PE_PIPE_DEPTH,
   parameter int MAX_K      = 256,
   parameter bit SKEW_EN    = 1'b1,
   parameter int DRAIN_LAT  = PE_ROWS + PE_COLS - 2 + PE_PIPE + 1,
   localparam int KW        = $clog2(MAX_K + 1)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    cmd_valid_i,
   output logic                                    cmd_ready_o,
   input  logic [KW-1:0]                           cmd_k_len_i,
   input  logic                                    cmd_accum_i,
   input  logic                                    op_valid_i,
   output logic                                    op_ready_o,
   input  logic                                    op_last_i,
   input  logic [PE_ROWS*DATA_WIDTH-1:0]           op_a_i,
   input  logic [PE_COLS*DATA_WIDTH-1:0]           op_b_i,
   output logic [PE_ROWS-1:0]                      pe_accum_en_o,
   output logic [PE_ROWS*DATA_WIDTH-1:0]           pe_a_o,
   output logic [PE_COLS*DATA_WIDTH-1:0]           pe_b_o,
   input  logic [PSUM_WIDTH*PE_ROWS*PE_COLS-1:0]   pe_result_i,
   output logic                                    res_valid_o,
   input  logic                                    res_ready_i,
   output logic [PSUM_WIDTH*PE_ROWS*PE_COLS-1:0]   res_data_o,
   output logic                                    busy_o,
   output logic                                    err_o
);
   import nmcu_pkg::*;

   localparam int CW = $clog2(DRAIN_LAT + 1);

   pe_seq_state_e                              state_q, state_d;
   logic [KW-1:0]                              k_len_q, k_len_d;
   logic [KW-1:0]                              beat_cnt_q, beat_cnt_d;
   logic [CW-1:0]                              drain_cnt_q, drain_cnt_d;
   logic                                       accum_q, accum_d;
   logic                                       err_q, err_d;
   logic                                       res_valid_q, res_valid_d;
   logic [PSUM_WIDTH*PE_ROWS*PE_COLS-1:0]      res_data_q, res_data_d;
   logic [PE_ROWS*DATA_WIDTH-1:0]              a_s0_q, a_s0_d;
   logic [PE_COLS*DATA_WIDTH-1:0]              b_s0_q, b_s0_d;
   logic                                       acc_s0_q, acc_s0_d;
   logic                                       last_beat;

   assign last_beat = beat_cnt_q == k_len_q - KW'(1);

   // Stage 0 defaults to a zero bubble with accumulate set, which leaves the array psums intact.
   always_comb begin
      state_d     = state_q;
      k_len_d     = k_len_q;
      beat_cnt_d  = beat_cnt_q;
      drain_cnt_d = drain_cnt_q;
      accum_d     = accum_q;
      err_d       = err_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      a_s0_d      = '0;
      b_s0_d      = '0;
      acc_s0_d    = 1'b1;
      case (state_q)
         IDLE: if (cmd_valid_i) begin
            k_len_d     = cmd_k_len_i;
            accum_d     = cmd_accum_i;
            beat_cnt_d  = '0;
            drain_cnt_d = CW'(DRAIN_LAT - 1);
            err_d       = err_q | (cmd_k_len_i == '0);
            state_d     = (cmd_k_len_i == '0) ? DRAIN : STREAM;
         end
         STREAM: if (op_valid_i) begin
            a_s0_d     = op_a_i;
            b_s0_d     = op_b_i;
            acc_s0_d   = (beat_cnt_q == '0) ? accum_q : 1'b1;
            beat_cnt_d = beat_cnt_q + KW'(1);
            err_d      = err_q | (op_last_i != last_beat);
            state_d    = last_beat ? DRAIN : STREAM;
         end
         DRAIN: begin
            drain_cnt_d = (drain_cnt_q == '0) ? drain_cnt_q : drain_cnt_q - CW'(1);
            res_data_d  = (drain_cnt_q == '0) ? pe_result_i : res_data_q;
            res_valid_d = drain_cnt_q == '0;
            state_d     = (drain_cnt_q == '0) ? RESULT : DRAIN;
         end
         RESULT: if (res_ready_i) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_len_q     <= '0;
         beat_cnt_q  <= '0;
         drain_cnt_q <= '0;
         accum_q     <= 1'b0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         a_s0_q      <= '0;
         b_s0_q      <= '0;
         acc_s0_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         beat_cnt_q  <= beat_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         accum_q     <= accum_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         a_s0_q      <= a_s0_d;
         b_s0_q      <= b_s0_d;
         acc_s0_q    <= acc_s0_d;
      end
   end

   assign cmd_ready_o = state_q == IDLE;
   assign op_ready_o  = state_q == STREAM;
   assign busy_o      = state_q != IDLE;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign err_o       = err_q;

   // The accumulate bit rides in the A lane so each row's enable lines up with its data.
   for (genvar r = 0; r < PE_ROWS; r++) begin : g_row
      logic [DATA_WIDTH:0] lane;
      skew_line #(.WIDTH(DATA_WIDTH + 1), .DEPTH(SKEW_EN ? r : 0)) u_skew (
         .clk  (clk),
         .rst_n(rst_n),
         .d_i  ({acc_s0_q, a_s0_q[r*DATA_WIDTH +: DATA_WIDTH]}),
         .q_o  (lane)
      );
      assign {pe_accum_en_o[r], pe_a_o[r*DATA_WIDTH +: DATA_WIDTH]} = lane;
   end

   for (genvar c = 0; c < PE_COLS; c++) begin : g_col
      skew_line #(.WIDTH(DATA_WIDTH), .DEPTH(SKEW_EN ? c : 0)) u_skew (
         .clk  (clk),
         .rst_n(rst_n),
         .d_i  (b_s0_q[c*DATA_WIDTH +: DATA_WIDTH]),
         .q_o  (pe_b_o[c*DATA_WIDTH +: DATA_WIDTH])
      );
   end
endmodule

// File: tb/tb_pe_stream_sequencer.sv
// tb_pe_stream_sequencer: directed tiles against a small systolic array model with
// hand-computed expected results, latencies and handshake behaviour.
module tb_pe_stream_sequencer;
   localparam int DW = 8, PW = 32, R = 4, C = 4, KW = 9, DL = 11;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 cmd_valid = 1'b0, cmd_accum = 1'b0;
   logic [KW-1:0]        cmd_k_len = '0;
   logic                 op_valid = 1'b0, op_last = 1'b0;
   logic [R*DW-1:0]      op_a = '0;
   logic [C*DW-1:0]      op_b = '0;
   logic                 res_ready = 1'b0;
   logic                 cmd_ready_o, op_ready_o, res_valid_o, busy_o, err_o;
   logic [R-1:0]         pe_accum_en_o;
   logic [R*DW-1:0]      pe_a_o;
   logic [C*DW-1:0]      pe_b_o;
   logic [PW*R*C-1:0]    pe_result, res_data_o;

   int n_vec = 0, n_err = 0, cyc = 0, hs_cyc = 0, f0, f3;
   bit arm = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pe_stream_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_k_len_i(cmd_k_len), .cmd_accum_i(cmd_accum),
      .op_valid_i(op_valid), .op_ready_o(op_ready_o), .op_last_i(op_last), .op_a_i(op_a), .op_b_i(op_b),
      .pe_accum_en_o(pe_accum_en_o), .pe_a_o(pe_a_o), .pe_b_o(pe_b_o), .pe_result_i(pe_result),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready), .res_data_o(res_data_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   // Array model: A moves right, B moves down, one register per hop; MAC, then two pipeline stages.
   logic [DW-1:0] ah [R][C], bv [R][C];
   logic          eh [R][C];
   logic [PW-1:0] ps [R][C], p1 [R][C], p2 [R][C];
   always @(posedge clk) begin
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            if (c == 0) begin
               ah[r][c] <= pe_a_o[r*DW +: DW];
               eh[r][c] <= pe_accum_en_o[r];
            end else begin
               ah[r][c] <= ah[r][c-1];
               eh[r][c] <= eh[r][c-1];
            end
            if (r == 0) bv[r][c] <= pe_b_o[c*DW +: DW];
            else        bv[r][c] <= bv[r-1][c];
            ps[r][c] <= eh[r][c] ? ps[r][c] + PW'(ah[r][c]) * PW'(bv[r][c]) : PW'(ah[r][c]) * PW'(bv[r][c]);
            p1[r][c] <= ps[r][c];
            p2[r][c] <= p1[r][c];
         end
   end
   always_comb begin
      pe_result = '0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) pe_result[(r*C+c)*PW +: PW] = p2[r][c];
   end

   always @(negedge clk) begin
      if (!arm) begin
         f0 = -1;
         f3 = -1;
      end else begin
         if (f0 < 0 && pe_a_o[7:0] != 0) f0 = cyc;
         if (f3 < 0 && pe_a_o[31:24] != 0) f3 = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cmd(input int k, input bit acc);
      int w = 0;
      cmd_valid = 1'b1;
      cmd_k_len = KW'(k);
      cmd_accum = acc;
      while (!cmd_ready_o && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("cmd_accept", 64'(w < 50), 1);
      hs_cyc = cyc + 1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic beats(input int n, input int k, input int val, input bit alt, input int bad);
      int sent = 0, w = 0;
      bit v = 1'b1;
      while (sent < n && w < 200) begin
         op_valid = v;
         op_last  = (sent == k - 1) || (sent == bad);
         op_a     = {R{DW'(val)}};
         op_b     = {C{DW'(val)}};
         if (v && op_ready_o) begin
            sent++;
            hs_cyc = cyc + 1;
         end
         @(negedge clk);
         w++;
         if (alt) v = !v;
      end
      op_valid = 1'b0;
      op_last  = 1'b0;
      op_a     = '0;
      op_b     = '0;
      chk("beats_sent", 64'(sent), 64'(n));
   endtask

   task automatic wait_res(input int exp_val, input string tag);
      int w = 0, nmatch = 0;
      bit rdy_low = 1'b1;
      while (!res_valid_o && w < 40) begin
         if (op_ready_o) rdy_low = 1'b0;
         @(negedge clk);
         w++;
      end
      chk({tag, "_latency"}, 64'(cyc - hs_cyc), DL);
      chk({tag, "_op_ready_low_in_drain"}, 64'(rdy_low), 1);
      for (int i = 0; i < R * C; i++) if (res_data_o[i*PW +: PW] == PW'(exp_val)) nmatch++;
      chk({tag, "_elem0"}, 64'(res_data_o[PW-1:0]), 64'(exp_val));
      chk({tag, "_elems_matching"}, 64'(nmatch), R * C);
   endtask

   task automatic take(input string tag);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_idle_cmd_ready"}, 64'(cmd_ready_o), 1);
      chk({tag, "_res_valid_clr"}, 64'(res_valid_o), 0);
   endtask

   initial begin
      bit seen, stable, held;
      logic [PW*R*C-1:0] snap;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready_o), 1);
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_res_valid", 64'(res_valid_o), 0);
      chk("rst_err", 64'(err_o), 0);
      chk("rst_op_ready", 64'(op_ready_o), 0);
      chk("rst_pe_accum", 64'(pe_accum_en_o), 0);
      rst_n = 1'b1;
      @(negedge clk);

      cmd(4, 1'b0);
      beats(2, 4, 1, 1'b0, -1);
      chk("mid_busy", 64'(busy_o), 1);
      chk("mid_pe_a_row0", 64'(pe_a_o[7:0]), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy_o), 0);
      chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 1);
      chk("mid_rst_res_valid", 64'(res_valid_o), 0);
      chk("mid_rst_pe_a", 64'(pe_a_o), 0);
      @(negedge clk);
      chk("mid_rst_pe_a_next", 64'(pe_a_o), 0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (res_valid_o || busy_o) seen = 1'b1;
      end
      chk("abandoned_no_result", 64'(seen), 0);

      cmd(4, 1'b0);
      beats(4, 4, 1, 1'b0, -1);
      wait_res(4, "k4");
      take("k4");

      arm = 1'b1;
      cmd(4, 1'b0);
      beats(4, 4, 1, 1'b1, -1);
      wait_res(4, "alt");
      arm = 1'b0;
      chk("skew_row3_lag", 64'(f3 - f0), 3);
      take("alt");

      cmd(2, 1'b0);
      beats(2, 2, 2, 1'b0, -1);
      wait_res(8, "b2b1");
      cmd_valid = 1'b1;
      cmd_k_len = KW'(2);
      cmd_accum = 1'b1;
      held = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (cmd_ready_o) held = 1'b1;
      end
      chk("b2b_no_cmd_ready", 64'(held), 0);
      take("b2b1");
      cmd(2, 1'b1);
      beats(2, 2, 2, 1'b0, -1);
      wait_res(16, "b2b2");
      take("b2b2");

      chk("err_before", 64'(err_o), 0);
      cmd(3, 1'b0);
      beats(3, 3, 1, 1'b0, 1);
      wait_res(3, "errk3");
      chk("err_set", 64'(err_o), 1);
      take("errk3");
      cmd(0, 1'b0);
      wait_res(3, "k0");
      chk("err_sticky", 64'(err_o), 1);
      take("k0");

      cmd(1, 1'b0);
      beats(1, 1, 5, 1'b0, -1);
      wait_res(25, "stall");
      snap = res_data_o;
      stable = 1'b1;
      held = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (res_data_o !== snap || !res_valid_o) stable = 1'b0;
         if (cmd_ready_o) held = 1'b1;
      end
      chk("stall_data_stable", 64'(stable), 1);
      chk("stall_cmd_ready_low", 64'(held), 0);
      take("stall");
      chk("stall_busy_clr", 64'(busy_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end
endmodule
